spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
- SPI target (slave) endpoint, the far end of the existing SPI master controller; mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first, CS active-low.
- Oversamples an external master's sck/cs/mosi in the clk domain and drives miso.
- Host side uses the same byte-buffered rd/wr/din/dout contract as the master controller: a TX FIFO supplies reply bytes and an RX FIFO collects received bytes.
- Intended for board-to-board links and for loopback verification of the master controller.

Parameters:
- FIFO_AW, 4, address width of each FIFO (depth 2**FIFO_AW = 16).
- FILL_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at a byte boundary.
- SYNC_STAGES, 2, synchronizer depth for sck, cs and mosi (legal values 2..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr  in  1  push din into TX FIFO; ignored when tx_full.
- din  in  8  reply byte.
- rd  in  1  pop RX FIFO when data_avail.
- dout  out  8  last popped RX byte.
- data_avail  out  1  RX FIFO not empty.
- tx_empty  out  1  TX FIFO empty.
- tx_full  out  1  TX FIFO full.
- rx_overflow  out  1  sticky: a received byte was dropped.
- clr_ovf  in  1  clears rx_overflow.
- busy  out  1  CS asserted (synced) and in SHIFT state.
- sck  in  1  SPI clock from master.
- cs  in  1  chip select, active-low.
- mosi  in  1  master data in.
- miso  out  1  data to master.
- miso_oe  out  1  miso output enable; pad tri-states when 0.

Behaviour:
- Reset (rst_n=0, asynchronous): FIFOs emptied; state IDLE; dout=0, miso=0, miso_oe=0, rx_overflow=0, busy=0, data_avail=0, tx_empty=1, tx_full=0; synchronizers are set to sck=0, cs=1, mosi=0.
- Synchronization: sck, cs and mosi each pass through SYNC_STAGES flops. Edges are detected from the last stage against a one-cycle-delayed copy. Requirement: f_sck <= f_clk/8.
- State machine:
  - IDLE -> SHIFT on a synced cs falling edge.
  - SHIFT -> IDLE on a synced cs rising edge.
  - cs rising mid-byte: the partial byte is discarded, nothing is pushed, bit_cnt is cleared, and miso_oe=0 on the next cycle.
- Byte load (cs fall, or the sck falling edge that follows the 8th rising edge):
  - If the TX FIFO is not empty, pop it into tx_sr; otherwise load FILL_BYTE.
  - miso = tx_sr[7] in the same cycle as the load.
  - miso_oe=1 for the whole of SHIFT.
- sck rising edge in SHIFT: rx_sr <= {rx_sr[6:0], mosi_sync}; bit_cnt (3-bit) increments and wraps 7->0.
- 8th rising edge (bit_cnt 7->0):
  - Push {rx_sr[6:0], mosi_sync} into the RX FIFO.
  - If the RX FIFO is full, drop the byte and set rx_overflow.
- sck falling edge in SHIFT, not a byte boundary: tx_sr shifts left and miso = next bit.
- sck edges in IDLE are ignored.
- Host pops: rd with data_avail high pops the RX FIFO; dout holds the registered value from the next cycle onward. rd with data_avail low has no effect.
- Host pushes: wr with tx_full high is dropped.
- Simultaneous events:
  - wr and a TX pop in the same cycle: both take effect; count unchanged.
  - rd and an RX push on the same cycle: both take effect.
  - clr_ovf and a new overflow on the same cycle: the overflow wins (flag stays 1).
- Flag timing: data_avail, tx_empty and tx_full are registered FIFO flags and update one cycle after the push or pop.

Optional Feature:
- Macro: SPI_PERIPHERAL_LSB_FIRST_EN.
- Defined: both shift registers operate LSB first. miso drives tx_sr[0] and tx_sr shifts right; rx_sr fills from bit 7 downward.
- Undefined: MSB first, as described above.
- All flags and timing are identical either way.

Decomposition:
- Package spi_pkg:
  - state enum typedef spi_periph_state_t {IDLE, SHIFT}
  - typedef byte_t = logic [7:0]
  - localparam SPI_FRAME_BITS = 8
- Sub-module spi_byte_fifo:
  - Synchronous FIFO, parameter AW, async active-low clear.
  - Registered empty/full flags.
  - Instantiated twice (TX and RX).

Test Plan:
- Basic exchange: preload TX with 8'hA5; master sends 8'h3C at clk/8. Master receives 8'hA5; data_avail rises; rd -> dout=8'h3C.
- Fill and back-to-back: TX empty; master sends 8'h01, 8'h02, 8'h03 in one CS frame. Master receives FF,FF,FF; RX pops return 01,02,03 in order.
- Overflow: 17 bytes with no rd. The 17th byte is dropped and rx_overflow=1. clr_ovf clears the flag. The first 16 bytes pop intact.
- CS abort: CS rises after 4 sck rising edges of 8'hF0. Nothing is pushed; miso_oe=0. The next full frame 8'h55 is received as 8'h55.
- Reset mid-frame: rst_n low after 3 bits. All outputs reach their reset values immediately; after release the next frame 8'hC3 is received correctly.
- LSB mode (with SPI_PERIPHERAL_LSB_FIRST_EN): TX 8'h01, master mosi 8'h80. The master sees the first miso bit = 1; RX pops 8'h80.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral slice.
package spi_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_periph_state_t;

    typedef logic [7:0] byte_t;

    localparam int unsigned SPI_FRAME_BITS = 8;

endpackage

// File: rtl/spi_byte_fifo.sv
// Byte-wide synchronous FIFO with registered empty/full flags and async active-low clear.
module spi_byte_fifo
    import spi_pkg::*;
#(
    parameter int unsigned AW = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  byte_t din,
    input  logic  pop,
    output byte_t dout,
    output logic  empty,
    output logic  full
);

    localparam int unsigned DEPTH = 2 ** AW;

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_d;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (push_ok && !pop_ok) begin
            count_d = count + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_d;
            // Flags are registered from the next count so they settle one cycle after the access.
            empty <= (count_d == '0);
            full  <= (count_d == (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target with byte-buffered TX/RX FIFOs on the host side.
// Define SPI_PERIPHERAL_LSB_FIRST_EN for LSB-first shifting (default MSB first).
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned FIFO_AW     = 4,
    parameter byte_t       FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] din,
    input  logic       rd,
    output logic [7:0] dout,
    output logic       data_avail,
    output logic       tx_empty,
    output logic       tx_full,
    output logic       rx_overflow,
    input  logic       clr_ovf,
    output logic       busy,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   cs_rise;
    logic                   cs_fall;

    spi_periph_state_t state_q;
    spi_periph_state_t state_d;

    byte_t                     tx_sr;
    logic [SPI_FRAME_BITS-2:0] rx_sr;
    logic [2:0]                bit_cnt;
    logic                      load_pend;

    logic  load;
    logic  tx_shift;
    logic  rx_shift;
    logic  byte_end;
    logic  abort;

    byte_t tx_head;
    byte_t rx_head;
    byte_t load_byte;
    byte_t tx_shifted;
    byte_t rx_next;
    logic  tx_pop;
    logic  rx_push;
    logic  rx_pop;
    logic  rx_empty;
    logic  rx_full;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_d;
    assign sck_fall = !sck_s && sck_d;
    assign cs_rise  = cs_s && !cs_d;
    assign cs_fall  = !cs_s && cs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    assign miso       = tx_sr[0];
    assign tx_shifted = {1'b0, tx_sr[7:1]};
    assign rx_next    = {mosi_s, rx_sr};
`else
    assign miso       = tx_sr[7];
    assign tx_shifted = {tx_sr[6:0], 1'b0};
    assign rx_next    = {rx_sr, mosi_s};
`endif

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        tx_shift = 1'b0;
        rx_shift = 1'b0;
        byte_end = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                    load    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sck_rise) begin
                    rx_shift = 1'b1;
                    byte_end = (bit_cnt == 3'(SPI_FRAME_BITS - 1));
                end else if (sck_fall) begin
                    // The falling edge after a completed byte reloads rather than shifts.
                    if (load_pend) begin
                        load = 1'b1;
                    end else begin
                        tx_shift = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_byte = tx_empty ? FILL_BYTE : tx_head;
    assign tx_pop    = load && !tx_empty;
    assign rx_push   = byte_end;
    assign rx_pop    = rd && data_avail;
    assign data_avail = !rx_empty;
    assign busy      = (state_q == SHIFT) && !cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            load_pend   <= 1'b0;
            miso_oe     <= 1'b0;
            dout        <= '0;
            rx_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            miso_oe <= (state_d == SHIFT);

            if (load) begin
                tx_sr <= load_byte;
            end else if (tx_shift) begin
                tx_sr <= tx_shifted;
            end

            if (abort) begin
                bit_cnt   <= '0;
                load_pend <= 1'b0;
            end else if (rx_shift) begin
                rx_sr     <= rx_next[SPI_FRAME_BITS-2:0];
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
                rx_sr     <= rx_next[SPI_FRAME_BITS-1:1];
`endif
                bit_cnt   <= bit_cnt + 3'd1;
                load_pend <= byte_end;
            end else if (load) begin
                load_pend <= 1'b0;
            end

            if (rx_pop) begin
                dout <= rx_head;
            end

            if (rx_push && rx_full) begin
                rx_overflow <= 1'b1;
            end else if (clr_ovf) begin
                rx_overflow <= 1'b0;
            end
        end
    end

    spi_byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr),
        .din   (din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    spi_byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .din   (rx_next),
        .pop   (rx_pop),
        .dout  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: a bit-banged SPI master plus a queue-based reference model.
module tb_spi_peripheral;
    import spi_pkg::*;

`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    localparam bit LSB_MODE = 1'b1;
`else
    localparam bit LSB_MODE = 1'b0;
`endif
    localparam int DEPTH = 16;
    localparam byte_t FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] din = '0;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       data_avail;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_overflow;
    logic       clr_ovf = 1'b0;
    logic       busy;
    logic       sck = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    always #5 clk = ~clk;

    spi_peripheral #(.FIFO_AW(4), .FILL_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .din         (din),
        .rd          (rd),
        .dout        (dout),
        .data_avail  (data_avail),
        .tx_empty    (tx_empty),
        .tx_full     (tx_full),
        .rx_overflow (rx_overflow),
        .clr_ovf     (clr_ovf),
        .busy        (busy),
        .sck         (sck),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    byte_t tx_model[$];
    int    rx_count = 0;
    bit    ovf_model = 1'b0;

    // Scoreboard queues
    byte_t exp_rx[$];
    byte_t exp_miso[$];
    byte_t obs_miso[$];
    byte_t frame_q[$];
    logic  pop_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) pop_seen <= rst_n && rd && data_avail;

    initial begin
        forever begin
            @(negedge clk);
            if (pop_seen) begin
                if (exp_rx.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rx_unexpected: got %0h expected no pop", dout);
                end else begin
                    check("rx_byte", {24'h0, dout}, {24'h0, exp_rx.pop_front()});
                end
            end
            while (obs_miso.size() > 0) begin
                if (exp_miso.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL miso_unexpected: got %0h expected nothing", obs_miso.pop_front());
                end else begin
                    check("miso_byte", {24'h0, obs_miso.pop_front()}, {24'h0, exp_miso.pop_front()});
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic xfer_bits(input byte_t b, input int nbits, output byte_t got, output bit first);
        got = '0;
        first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = LSB_MODE ? i : 7 - i;
            mosi = b[idx];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            got[idx] = miso;
            if (i == 0) first = miso;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    // Each frame of N bytes performs N+1 loads: at CS fall and after every completed byte.
    task automatic send_frame(output bit first_bit);
        byte_t got;
        bit    fb;
        int    n;
        n = frame_q.size();
        for (int i = 0; i <= n; i++) begin
            byte_t l;
            l = (tx_model.size() > 0) ? tx_model.pop_front() : FILL;
            if (i < n) exp_miso.push_back(l);
        end
        for (int i = 0; i < n; i++) begin
            if (rx_count < DEPTH) begin
                exp_rx.push_back(frame_q[i]);
                rx_count++;
            end else begin
                ovf_model = 1'b1;
            end
        end
        first_bit = 1'b0;
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            xfer_bits(frame_q[i], 8, got, fb);
            if (i == 0) first_bit = fb;
            obs_miso.push_back(got);
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        frame_q.delete();
    endtask

    task automatic host_write(input byte_t b);
        @(negedge clk);
        wr = 1'b1;
        din = b;
        @(negedge clk);
        wr = 1'b0;
        if (tx_model.size() < DEPTH) tx_model.push_back(b);
    endtask

    task automatic drain();
        while (rx_count > 0) begin
            @(negedge clk);
            rd = 1'b1;
            @(negedge clk);
            rd = 1'b0;
            rx_count--;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_tx_empty"}, {31'h0, tx_empty}, {31'h0, tx_model.size() == 0});
        check({tag, "_tx_full"}, {31'h0, tx_full}, {31'h0, tx_model.size() == DEPTH});
        check({tag, "_data_avail"}, {31'h0, data_avail}, {31'h0, rx_count > 0});
        check({tag, "_rx_overflow"}, {31'h0, rx_overflow}, {31'h0, ovf_model});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, {24'h0, dout}, 32'h0);
        check({tag, "_miso"}, {31'h0, miso}, 32'h0);
        check({tag, "_miso_oe"}, {31'h0, miso_oe}, 32'h0);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_data_avail"}, {31'h0, data_avail}, 32'h0);
        check({tag, "_tx_empty"}, {31'h0, tx_empty}, 32'h1);
        check({tag, "_tx_full"}, {31'h0, tx_full}, 32'h0);
        check({tag, "_rx_overflow"}, {31'h0, rx_overflow}, 32'h0);
    endtask

    initial begin
        bit    fb;
        byte_t got;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic exchange
        host_write(8'hA5);
        check_flags("preload");
        frame_q.push_back(8'h3C);
        send_frame(fb);
        check_flags("basic");
        drain();
        check_flags("basic_drained");

        // First-bit ordering
        host_write(8'h01);
        frame_q.push_back(8'h80);
        send_frame(fb);
        check("first_miso_bit", {31'h0, fb}, {31'h0, LSB_MODE});
        drain();

        // rd with nothing available: no pop
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        repeat (2) @(negedge clk);

        // Fill bytes, back-to-back
        frame_q.push_back(8'h01);
        frame_q.push_back(8'h02);
        frame_q.push_back(8'h03);
        send_frame(fb);
        drain();

        // TX full and RX overflow
        for (int i = 0; i < DEPTH + 1; i++) host_write(byte_t'($urandom));
        check_flags("tx_full");
        for (int i = 0; i < DEPTH + 1; i++) frame_q.push_back(byte_t'($urandom));
        send_frame(fb);
        check_flags("overflow");
        @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        ovf_model = 1'b0;
        @(negedge clk);
        check_flags("clr_ovf");
        drain();

        // CS abort after four bits
        cs = 1'b0;
        if (tx_model.size() > 0) void'(tx_model.pop_front());
        repeat (8) @(negedge clk);
        check("abort_miso_oe_on", {31'h0, miso_oe}, 32'h1);
        check("abort_busy_on", {31'h0, busy}, 32'h1);
        xfer_bits(8'hF0, 4, got, fb);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
        check("abort_miso_oe_off", {31'h0, miso_oe}, 32'h0);
        check("abort_busy_off", {31'h0, busy}, 32'h0);
        check_flags("abort");
        frame_q.push_back(8'h55);
        send_frame(fb);
        drain();

        // Reset mid-frame
        host_write(byte_t'($urandom));
        host_write(byte_t'($urandom));
        cs = 1'b0;
        repeat (8) @(negedge clk);
        xfer_bits(8'hC3, 3, got, fb);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tx_model.delete();
        rx_count = 0;
        ovf_model = 1'b0;
        cs = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        frame_q.push_back(8'hC3);
        send_frame(fb);
        check_flags("post_reset");
        drain();

        // Randomized traffic
        for (int it = 0; it < 8; it++) begin
            int k;
            int n;
            k = $urandom_range(0, 4);
            n = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) host_write(byte_t'($urandom));
            for (int j = 0; j < n; j++) frame_q.push_back(byte_t'($urandom));
            send_frame(fb);
            check_flags("rand");
            drain();
        end

        repeat (10) @(negedge clk);
        check("exp_rx_left", exp_rx.size(), 32'h0);
        check("exp_miso_left", exp_miso.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
